// File: rtl/serial_receiver.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits LSB first,
// even-parity bit and stop bit, delivering good words on a valid/ready port.
module serial_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_error,
    output logic             framing_error,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] shift, shift_next;
    logic             parity_bit, parity_bit_next;

    logic stop_edge;
    logic frame_framing_bad;
    logic frame_parity_bad;
    logic frame_good;
    logic load_word;
    logic drop_word;
    logic accept;

    // Output handshake: a word moves to the consumer on every edge where
    // data_valid && data_ready; data_valid drops afterwards unless that same
    // edge loads a fresh word, in which case it stays high with the new data.
    assign accept = data_valid && data_ready;

    // Frame evaluation on the STOP edge: a high stop bit beats bad parity.
    assign stop_edge         = (state == STOP);
    assign frame_framing_bad = stop_edge && serial_in;
    assign frame_parity_bad  = stop_edge && !serial_in && (parity_bit != ^shift);
    assign frame_good        = stop_edge && !serial_in && (parity_bit == ^shift);
    assign load_word         = frame_good && (!data_valid || data_ready);
    assign drop_word         = frame_good && data_valid && !data_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            shift      <= shift_next;
            parity_bit <= parity_bit_next;
        end
    end

    always_comb begin
        state_next      = state;
        count_next      = count;
        shift_next      = shift;
        parity_bit_next = parity_bit;
        case (state)
            IDLE: begin
                if (serial_in) begin
                    state_next = DATA;
                    count_next = '0;
                end
            end
            DATA: begin
                // LSB arrives first, so shifting in from the top leaves d[0] at bit 0.
                shift_next = {serial_in, shift[WIDTH-1:1]};
                if (count == CW'(WIDTH - 1)) begin
                    state_next = PARITY;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            PARITY: begin
                parity_bit_next = serial_in;
                state_next      = STOP;
            end
            STOP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            parity_error  <= frame_parity_bad;
            framing_error <= frame_framing_bad;
            overrun       <= drop_word;
            if (load_word) begin
                data_out   <= shift;
                data_valid <= 1'b1;
            end else if (accept) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: directed scenarios plus random framed traffic,
// checked every cycle against a frame-level reference model.
module tb_serial_receiver;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         serial_in;
    logic         data_ready;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         parity_error;
    logic         framing_error;
    logic         overrun;

    serial_receiver #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .serial_in    (serial_in),
        .data_ready   (data_ready),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .overrun      (overrun)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_pe, m_fe, m_ov;
    logic [W-1:0] exp_q[$];

    // ready policy: 0 never, 1 always, 2 random, 3 only on stop edges
    int ready_mode = 0;
    int cyc = 0;
    int xfer_cyc[$];
    logic [W-1:0] xfer_word_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        check("data_valid", 32'(data_valid), 32'(m_valid));
        check("data_out", 32'(data_out), 32'(m_data));
        check("parity_error", 32'(parity_error), 32'(m_pe));
        check("framing_error", 32'(framing_error), 32'(m_fe));
        check("overrun", 32'(overrun), 32'(m_ov));
    endtask

    // Frame-level reference: applied at the edge that samples a frame's stop bit.
    task automatic model_edge(input logic rdy, input logic last, input logic [W-1:0] d,
                              input logic p, input logic s);
        logic load;
        load = 1'b0;
        m_pe = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (last) begin
            if (s)                        m_fe = 1'b1;
            else if (p != (^d))           m_pe = 1'b1;
            else if (!m_valid || rdy)     load = 1'b1;
            else                          m_ov = 1'b1;
        end
        if (load) begin
            m_valid = 1'b1;
            m_data  = d;
            exp_q.push_back(d);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // driver: one line bit per call
    task automatic cycle(input logic sin, input logic last, input logic [W-1:0] d,
                         input logic p, input logic s);
        logic rdy;
        logic xfer;
        logic [W-1:0] xw;
        case (ready_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = last;
        endcase
        serial_in  = sin;
        data_ready = rdy;
        xfer = data_valid && rdy;
        xw   = data_out;
        @(posedge clock);
        cyc++;
        if (xfer) begin
            xfer_cyc.push_back(cyc);
            xfer_word_log.push_back(xw);
            if (exp_q.size() == 0) check("sb_unexpected_xfer", 32'(xw), 32'hFFFF_FFFF);
            else                   check("sb_word", 32'(xw), 32'(exp_q.pop_front()));
        end
        model_edge(rdy, last, d, p, s);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pflip, input logic s);
        logic p;
        p = (^d) ^ pflip;
        cycle(1'b1, 1'b0, d, p, s);
        for (int i = 0; i < W; i++) cycle(d[i], 1'b0, d, p, s);
        cycle(p, 1'b0, d, p, s);
        cycle(s, 1'b1, d, p, s);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        serial_in  = 1'b0;
        data_ready = 1'b0;
        @(posedge clock);
        cyc++;
        m_valid = 1'b0;
        m_data  = '0;
        m_pe    = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        exp_q.delete();
        #1;
        check_outputs();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        serial_in  = 1'b0;
        data_ready = 1'b0;
        m_valid = 1'b0; m_data = '0; m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        @(posedge clock);
        #1;
        do_reset();

        // 0xA5 held unaccepted, then one accept cycle
        ready_mode = 0;
        send_frame(8'hA5, 1'b0, 1'b0);
        check("a5_valid", 32'(data_valid), 32'd1);
        check("a5_data", 32'(data_out), 32'hA5);
        ready_mode = 1;
        idle(1);
        ready_mode = 0;
        check("a5_drained", 32'(data_valid), 32'd0);
        check("a5_hold", 32'(data_out), 32'hA5);
        idle(2);

        // bad parity, then bad stop bit followed by a quiet line
        send_frame(8'h01, 1'b1, 1'b0);
        check("pe_pulse", 32'(parity_error), 32'd1);
        check("pe_no_valid", 32'(data_valid), 32'd0);
        idle(1);
        check("pe_one_cycle", 32'(parity_error), 32'd0);
        send_frame(8'h03, 1'b0, 1'b1);
        check("fe_pulse", 32'(framing_error), 32'd1);
        check("fe_only", 32'(parity_error), 32'd0);
        idle(3);

        // back-to-back frames with the consumer always ready
        ready_mode = 1;
        xfer_cyc.delete();
        xfer_word_log.delete();
        send_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0);
        idle(2);
        check("b2b_count", 32'(xfer_cyc.size()), 32'd2);
        if (xfer_cyc.size() == 2) begin
            check("b2b_first", 32'(xfer_word_log[0]), 32'h3C);
            check("b2b_second", 32'(xfer_word_log[1]), 32'hC3);
            check("b2b_spacing", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd11);
        end

        // overrun, then refill on the same edge as acceptance
        ready_mode = 0;
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_keep", 32'(data_out), 32'h11);
        ready_mode = 1;
        idle(1);
        ready_mode = 0;
        send_frame(8'h11, 1'b0, 1'b0);
        ready_mode = 3;
        send_frame(8'h22, 1'b0, 1'b0);
        check("refill_valid", 32'(data_valid), 32'd1);
        check("refill_data", 32'(data_out), 32'h22);
        check("refill_no_ovr", 32'(overrun), 32'd0);
        ready_mode = 1;
        idle(2);

        // reset at data bit 4 of 0x0F, trailing zeros, then 0xFF
        ready_mode = 0;
        cycle(1'b1, 1'b0, 8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h0F, 1'b0, 1'b0);
        do_reset();
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        idle(5);
        send_frame(8'hFF, 1'b0, 1'b0);
        check("ff_data", 32'(data_out), 32'hFF);

        // quiet line for 50 cycles with the word still pending
        idle(50);
        check("idle_data", 32'(data_out), 32'hFF);
        check("idle_valid", 32'(data_valid), 32'd1);

        // random traffic
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            logic [W-1:0] d;
            logic pf;
            logic sb;
            d  = W'($urandom_range(0, 255));
            pf = ($urandom_range(0, 5) == 0);
            sb = ($urandom_range(0, 7) == 0);
            send_frame(d, pf, sb);
            idle($urandom_range(0, 3));
        end

        ready_mode = 1;
        idle(3);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Framed serial-to-parallel receiver: the receiving end of the one-bit-per-clock serial link that the parallel-load `shift_register` drives out. It detects a start bit and shifts in WIDTH data bits LSB first. It then checks an even-parity bit and a stop bit, and presents the recovered word on a valid/ready output port. It sits between the serial line and any parallel consumer (register file, FIFO, datapath).

## Interface
- WIDTH, 8, number of data bits per frame (≥2).
- clock  input  1  sole clock; everything samples on posedge clock.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  serial line, one bit per clock; idles at 0.
- data_ready  input  1  consumer can accept data_out this cycle.
- data_out  output  WIDTH  last good received word.
- data_valid  output  1  data_out holds a word not yet accepted.
- parity_error  output  1  one-cycle pulse: frame discarded, bad parity.
- framing_error  output  1  one-cycle pulse: frame discarded, stop bit was 1.
- overrun  output  1  one-cycle pulse: good frame dropped, output still full.

## Operation
- Frame, WIDTH+3 bits, one per cycle: start bit (1), d[0]..d[WIDTH-1], parity bit p, stop bit (0).
- Parity is even: the frame is good only if p equals the XOR of the data bits.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: serial_in=1 → DATA with bit counter 0. serial_in=0 → stay.
  - DATA: store serial_in into shift/holding bits at index counter and increment the counter. After the WIDTH-th data bit → PARITY. The counter is $clog2(WIDTH)+1 bits wide and never wraps mid-frame.
  - PARITY: latch p → STOP.
  - STOP: evaluate the frame → IDLE unconditionally. A 1 sampled in STOP is never treated as a start bit.
- Frame evaluation at the STOP edge, in priority order:
  - Stop bit = 1: framing_error pulse, frame discarded.
  - Parity mismatch: parity_error pulse, frame discarded.
  - Good frame, and output is empty or being accepted this edge (data_valid=0, or data_valid&&data_ready): load data_out and set data_valid=1.
  - Good frame while data_valid=1 and data_ready=0: overrun pulse. The new word is dropped and the old data_out is kept.
- Output handshake: a transfer occurs at any edge with data_valid&&data_ready. data_valid then falls, unless the same edge loads a new word; in that case it stays 1 and data_out updates.
- data_out changes only on a good-frame load; it holds its value after acceptance.
- Error pulses and overrun never affect data_valid or data_out.

## Timing
- Reset values: state=IDLE, counter=0, data_out=0, data_valid=0, parity_error=0, framing_error=0, overrun=0.
- Reset takes priority over every other event, including mid-frame. A partial frame is abandoned and no pulse is produced.
- Latency: start bit sampled at edge N gives the stop bit at edge N+WIDTH+2. data_valid/data_out (or an error pulse) are visible in the cycle after that edge.
- Back-to-back frames: the next start bit may be presented in the cycle right after the stop bit (zero idle gap). Sustained throughput is one word per WIDTH+3 cycles.
- Error and overrun pulses last exactly one cycle (high only in the cycle after the STOP edge).
- data_ready is ignored while data_valid=0.
- data_valid may remain high indefinitely while data_ready=0.

## Test plan
- Reset, then send 0xA5 (WIDTH=8; line 1,1,0,1,0,0,1,0,1,0,0 starting at edge 0) with data_ready=0 → data_valid=1, data_out=0xA5 after edge 10, no pulses. Assert data_ready for one cycle → data_valid=0 next cycle, data_out stays 0xA5.
- Send 0x01 with parity bit 0 → parity_error high for one cycle, data_valid stays 0. Send 0x03 with stop bit 1 → framing_error pulse only, and the FSM is back in IDLE (a following 0 keeps it idle).
- Two good frames back-to-back (0x3C then 0xC3, zero gap), data_ready=1 throughout → two one-word transfers, 0x3C then 0xC3, exactly 11 cycles apart.
- Good frame 0x11 left unaccepted, then good frame 0x22 with data_ready=0 → overrun pulse, data_out stays 0x11. Repeat with data_ready=1 on the second STOP edge → data_valid stays 1 and data_out=0x22.
- Assert reset at DATA bit 4 of a frame → all outputs 0 next cycle. Remaining frame bits that are 0 are ignored. A fresh frame 0xFF is then received correctly.
- Idle line held at 0 for 50 cycles → no outputs change.
